// File: rtl/bits_test_seq.sv
// rtl/bits_test_seq.sv - pattern sequencer driving the bits test generator pattern select
module bits_test_seq #(
    parameter int CNT_W  = 16,
    parameter int LOOP_W = 8,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [3:0]        i_pat_en,
    input  logic [CNT_W-1:0]  i_dwell,
    input  logic [LOOP_W-1:0] i_loops,
    output logic [1:0]        o_test_patten,
    output logic              o_pat_valid,
    output logic              o_pat_switch,
    output logic              o_busy,
    output logic              o_done,
    output logic [LOOP_W-1:0] o_loop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_DWELL,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          pat_q, pat_d;
    logic                valid_q, valid_d;
    logic                switch_q, switch_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [LOOP_W-1:0]   loop_cnt_q, loop_cnt_d;
    logic [3:0]          mask_q, mask_d;
    logic [CNT_W-1:0]    dwell_q, dwell_d;
    logic [LOOP_W-1:0]   loops_q, loops_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [3:0]          above;
    logic [LOOP_W-1:0]   loop_inc;

    function automatic logic [1:0] lowest_idx(input logic [3:0] mask);
        logic [1:0] res;
        res = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (mask[k]) begin
                res = 2'(k);
            end
        end
        return res;
    endfunction

    // Enabled patterns strictly above the current code.
    assign above    = mask_q & (4'b1110 << pat_q);
    assign loop_inc = (loop_cnt_q == '1) ? loop_cnt_q : loop_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        valid_d    = valid_q;
        switch_d   = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        loop_cnt_d = loop_cnt_q;
        mask_d     = mask_q;
        dwell_d    = dwell_q;
        loops_d    = loops_q;
        cnt_d      = cnt_q;

        case (state_q)
            S_IDLE: begin
                pat_d   = 2'b00;
                busy_d  = 1'b0;
                valid_d = 1'b0;
                if (i_start && (i_pat_en != 4'b0000)) begin
                    mask_d     = i_pat_en;
                    dwell_d    = (i_dwell == '0) ? CNT_W'(1) : i_dwell;
                    loops_d    = i_loops;
                    loop_cnt_d = '0;
                    pat_d      = lowest_idx(i_pat_en);
                    switch_d   = 1'b1;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (i_abort) begin
                    state_d = S_IDLE;
                    pat_d   = 2'b00;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    state_d = S_DWELL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DWELL: begin
                if (i_abort) begin
                    state_d = S_IDLE;
                    pat_d   = 2'b00;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == dwell_q - 1'b1) begin
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    if (above != 4'b0000) begin
                        pat_d    = lowest_idx(above);
                        switch_d = 1'b1;
                        state_d  = S_SETTLE;
                    end else begin
                        loop_cnt_d = loop_inc;
                        if ((loops_q != '0) && (loop_inc == loops_q)) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            pat_d   = 2'b00;
                        end else begin
                            // Wrap pulses the switch even when the code is unchanged.
                            pat_d    = lowest_idx(mask_q);
                            switch_d = 1'b1;
                            state_d  = S_SETTLE;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                pat_d   = 2'b00;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pat_q      <= 2'b00;
            valid_q    <= 1'b0;
            switch_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            loop_cnt_q <= '0;
            mask_q     <= 4'b0000;
            dwell_q    <= '0;
            loops_q    <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            valid_q    <= valid_d;
            switch_q   <= switch_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            loop_cnt_q <= loop_cnt_d;
            mask_q     <= mask_d;
            dwell_q    <= dwell_d;
            loops_q    <= loops_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_test_patten = pat_q;
    assign o_pat_valid   = valid_q;
    assign o_pat_switch  = switch_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_loop_cnt    = loop_cnt_q;

endmodule

// File: tb/tb_bits_test_seq.sv
// tb/tb_bits_test_seq.sv - directed self-checking bench for bits_test_seq
module tb_bits_test_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic        i_abort;
    logic [3:0]  i_pat_en;
    logic [15:0] i_dwell;
    logic [7:0]  i_loops;
    logic [1:0]  o_test_patten;
    logic        o_pat_valid;
    logic        o_pat_switch;
    logic        o_busy;
    logic        o_done;
    logic [7:0]  o_loop_cnt;

    int n_vec = 0;
    int n_err = 0;

    bits_test_seq #(.CNT_W(16), .LOOP_W(8), .SETTLE(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_pat_en     (i_pat_en),
        .i_dwell      (i_dwell),
        .i_loops      (i_loops),
        .o_test_patten(o_test_patten),
        .o_pat_valid  (o_pat_valid),
        .o_pat_switch (o_pat_switch),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_loop_cnt   (o_loop_cnt)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [13:0] got;
        rst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
        i_pat_en = 4'b0000; i_dwell = 16'd0; i_loops = 8'd0;
        step; step;
        got = {o_test_patten, o_pat_valid, o_pat_switch, o_busy, o_done, o_loop_cnt};
        n_vec++;
        if (got !== 14'b0) begin
            $display("FAIL reset got=%b exp=%b", got, 14'b0); n_err++;
        end
        rst = 1'b0;
        step;
    endtask

    task automatic test_single;
        logic [5:0]  got, exp;
        logic [13:0] gf, ef;
        i_pat_en = 4'b0010; i_dwell = 16'd4; i_loops = 8'd1; i_start = 1'b1;
        step;
        i_start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            exp = {2'b01, 1'(c >= 2), 1'(c == 0), 1'b1, 1'b0};
            got = {o_test_patten, o_pat_valid, o_pat_switch, o_busy, o_done};
            n_vec++;
            if (got !== exp) begin
                $display("FAIL single c=%0d got=%b exp=%b", c, got, exp); n_err++;
            end
            step;
        end
        ef = {2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
        gf = {o_test_patten, o_pat_valid, o_pat_switch, o_busy, o_done, o_loop_cnt};
        n_vec++;
        if (gf !== ef) begin
            $display("FAIL single_done got=%b exp=%b", gf, ef); n_err++;
        end
    endtask

    task automatic test_back_to_back;
        logic [11:0] got, exp;
        // Called while the DUT sits in DONE; start there must be ignored.
        i_start = 1'b1;
        step;
        n_vec++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            $display("FAIL b2b_done_cycle busy=%b done=%b exp busy=0 done=0", o_busy, o_done); n_err++;
        end
        step;
        i_start = 1'b0;
        exp = {2'b01, 1'b1, 1'b1, 8'd0};
        got = {o_test_patten, o_pat_switch, o_busy, o_loop_cnt};
        n_vec++;
        if (got !== exp) begin
            $display("FAIL b2b_restart got=%b exp=%b", got, exp); n_err++;
        end
        i_abort = 1'b1;
        step;
        i_abort = 1'b0;
        n_vec++;
        if (o_busy !== 1'b0) begin
            $display("FAIL b2b_abort busy=%b exp=0", o_busy); n_err++;
        end
    endtask

    task automatic test_order_wrap;
        logic [1:0]  codes [6];
        logic [4:0]  got, exp;
        logic [11:0] gf, ef;
        int          nsw;
        codes = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3};
        nsw = 0;
        i_pat_en = 4'b1101; i_dwell = 16'd3; i_loops = 8'd2; i_start = 1'b1;
        step;
        i_start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            exp = {codes[c / 5], 1'((c % 5) >= 2), 1'((c % 5) == 0), 1'b1};
            got = {o_test_patten, o_pat_valid, o_pat_switch, o_busy};
            if (o_pat_switch === 1'b1) nsw++;
            n_vec++;
            if (got !== exp) begin
                $display("FAIL order c=%0d got=%b exp=%b", c, got, exp); n_err++;
            end
            step;
        end
        n_vec++;
        if (nsw != 6) begin
            $display("FAIL order_switches got=%0d exp=6", nsw); n_err++;
        end
        ef = {2'b00, 1'b0, 1'b1, 8'd2};
        gf = {o_test_patten, o_busy, o_done, o_loop_cnt};
        n_vec++;
        if (gf !== ef) begin
            $display("FAIL order_done got=%b exp=%b", gf, ef); n_err++;
        end
        step;
    endtask

    task automatic test_infinite;
        logic [12:0] got, exp;
        logic        saw_done;
        saw_done = 1'b0;
        i_pat_en = 4'b0001; i_dwell = 16'd1; i_loops = 8'd0; i_start = 1'b1;
        step;
        i_start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (o_done === 1'b1) saw_done = 1'b1;
            n_vec++;
            if (o_loop_cnt !== 8'(c / 3)) begin
                $display("FAIL inf_cnt c=%0d got=%0d exp=%0d", c, o_loop_cnt, c / 3); n_err++;
            end
            step;
        end
        n_vec++;
        if (o_loop_cnt !== 8'd10) begin
            $display("FAIL inf_cnt10 got=%0d exp=10", o_loop_cnt); n_err++;
        end
        i_abort = 1'b1;
        step;
        i_abort = 1'b0;
        exp = {2'b00, 1'b0, 1'b0, 1'b0, 8'd10};
        got = {o_test_patten, o_pat_valid, o_busy, o_done, o_loop_cnt};
        n_vec++;
        if (got !== exp) begin
            $display("FAIL inf_abort got=%b exp=%b", got, exp); n_err++;
        end
        step;
        if (o_done === 1'b1) saw_done = 1'b1;
        n_vec++;
        if (saw_done !== 1'b0 || o_busy !== 1'b0 || o_loop_cnt !== 8'd10) begin
            $display("FAIL inf_nodone saw_done=%b busy=%b cnt=%0d exp 0,0,10", saw_done, o_busy, o_loop_cnt); n_err++;
        end
    endtask

    task automatic test_dwell_zero;
        logic [4:0]  got, exp;
        logic [9:0]  gf, ef;
        int          nval;
        nval = 0;
        i_pat_en = 4'b0011; i_dwell = 16'd0; i_loops = 8'd1; i_start = 1'b1;
        step;
        i_start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            exp = {2'(c / 3), 1'((c % 3) == 2), 1'((c % 3) == 0), 1'b1};
            got = {o_test_patten, o_pat_valid, o_pat_switch, o_busy};
            if (o_pat_valid === 1'b1) nval++;
            n_vec++;
            if (got !== exp) begin
                $display("FAIL dwell0 c=%0d got=%b exp=%b", c, got, exp); n_err++;
            end
            step;
        end
        n_vec++;
        if (nval != 2) begin
            $display("FAIL dwell0_valid got=%0d exp=2", nval); n_err++;
        end
        ef = {1'b1, 1'b0, 8'd1};
        gf = {o_done, o_busy, o_loop_cnt};
        n_vec++;
        if (gf !== ef) begin
            $display("FAIL dwell0_done got=%b exp=%b", gf, ef); n_err++;
        end
        step;
    endtask

    task automatic test_ignored;
        logic [4:0]  got, exp;
        logic [10:0] gf, ef;
        i_pat_en = 4'b0000; i_dwell = 16'd2; i_loops = 8'd1; i_start = 1'b1;
        step;
        i_start = 1'b0;
        n_vec++;
        if (o_busy !== 1'b0 || o_pat_switch !== 1'b0) begin
            $display("FAIL mask0 busy=%b switch=%b exp 0,0", o_busy, o_pat_switch); n_err++;
        end
        i_pat_en = 4'b0100; i_dwell = 16'd2; i_loops = 8'd1; i_start = 1'b1;
        step;
        i_start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                i_start = 1'b1; i_pat_en = 4'b0001; i_dwell = 16'd9; i_loops = 8'd5;
            end
            if (c == 2) i_start = 1'b0;
            exp = {2'b10, 1'(c >= 2), 1'(c == 0), 1'b1};
            got = {o_test_patten, o_pat_valid, o_pat_switch, o_busy};
            n_vec++;
            if (got !== exp) begin
                $display("FAIL busy_start c=%0d got=%b exp=%b", c, got, exp); n_err++;
            end
            step;
        end
        ef = {2'b00, 1'b1, 8'd1};
        gf = {o_test_patten, o_done, o_loop_cnt};
        n_vec++;
        if (gf !== ef) begin
            $display("FAIL busy_start_done got=%b exp=%b", gf, ef); n_err++;
        end
        step;
        i_pat_en = 4'b0001; i_dwell = 16'd2; i_loops = 8'd0; i_start = 1'b1;
        step;
        i_start = 1'b0;
        step;
        i_start = 1'b1; i_abort = 1'b1;
        step;
        i_start = 1'b0; i_abort = 1'b0;
        exp = {2'b00, 1'b0, 1'b0, 1'b0};
        got = {o_test_patten, o_pat_valid, o_pat_switch, o_busy};
        n_vec++;
        if (got !== exp) begin
            $display("FAIL abort_wins got=%b exp=%b", got, exp); n_err++;
        end
        step;
        n_vec++;
        if (o_busy !== 1'b0) begin
            $display("FAIL abort_stay_idle busy=%b exp=0", o_busy); n_err++;
        end
        i_start = 1'b1; i_abort = 1'b1;
        step;
        i_start = 1'b0; i_abort = 1'b0;
        exp = {2'b00, 1'b0, 1'b1, 1'b1};
        got = {o_test_patten, o_pat_valid, o_pat_switch, o_busy};
        n_vec++;
        if (got !== exp) begin
            $display("FAIL idle_abort_ignored got=%b exp=%b", got, exp); n_err++;
        end
        i_abort = 1'b1;
        step;
        i_abort = 1'b0;
        n_vec++;
        if (o_busy !== 1'b0) begin
            $display("FAIL idle_abort_cleanup busy=%b exp=0", o_busy); n_err++;
        end
    endtask

    task automatic test_reset_mid;
        logic [13:0] gf;
        logic [4:0]  got, exp;
        logic [9:0]  g2, e2;
        i_pat_en = 4'b0001; i_dwell = 16'd4; i_loops = 8'd1; i_start = 1'b1;
        step;
        i_start = 1'b0;
        step; step; step;
        n_vec++;
        if (o_pat_valid !== 1'b1 || o_busy !== 1'b1) begin
            $display("FAIL rmid_pre valid=%b busy=%b exp 1,1", o_pat_valid, o_busy); n_err++;
        end
        #2 rst = 1'b1;
        #1;
        gf = {o_test_patten, o_pat_valid, o_pat_switch, o_busy, o_done, o_loop_cnt};
        n_vec++;
        if (gf !== 14'b0) begin
            $display("FAIL rmid_async got=%b exp=%b", gf, 14'b0); n_err++;
        end
        step;
        rst = 1'b0;
        step;
        i_pat_en = 4'b1000; i_dwell = 16'd1; i_loops = 8'd1; i_start = 1'b1;
        step;
        i_start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            exp = {2'b11, 1'(c == 2), 1'(c == 0), 1'b1};
            got = {o_test_patten, o_pat_valid, o_pat_switch, o_busy};
            n_vec++;
            if (got !== exp) begin
                $display("FAIL rmid_fresh c=%0d got=%b exp=%b", c, got, exp); n_err++;
            end
            step;
        end
        e2 = {1'b1, 1'b0, 8'd1};
        g2 = {o_done, o_busy, o_loop_cnt};
        n_vec++;
        if (g2 !== e2) begin
            $display("FAIL rmid_done got=%b exp=%b", g2, e2); n_err++;
        end
        step;
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_order_wrap;
        test_infinite;
        test_dwell_zero;
        test_ignored;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
